// File: rtl/result_collect.sv
`default_nettype none
// ============================================================================
// Module  : result_collect
// Brief   : De-skews systolic-array output rows and assembles N x N result
//           matrices behind a valid/ready output register (N >= 2).
//           Define RESULT_COLLECT_OVF_EN to add the sticky o_ovf drop flag.
// Revision: 1.0 - initial release
// ============================================================================
module result_collect #(
    parameter int W = 32,
    parameter int N = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic [W*N-1:0]   i_row,
    input  logic             i_ready,
    output logic [W*N*N-1:0] o_C,
    output logic             o_valid,
    output logic             o_busy
`ifdef RESULT_COLLECT_OVF_EN
    ,
    output logic             o_ovf
`endif
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    row;
    logic [CW-1:0]    cnt;
    logic [W*N-1:0]   al_row;
    logic             v_raw;
    logic             v_al;
    logic             v_in;
    logic             last_in;
    logic             done;
    logic             load;
    logic [W*N*N-1:0] next_C;
    logic [W*N-1:0]   asm_buf [0:N-2];

    // Lane c is delayed N-1-c cycles so every lane lines up with lane N-1.
    genvar c;
    generate
        for (c = 0; c < N; c++) begin : g_lane
            localparam int D = N - 1 - c;
            if (D == 0) begin : g_pass
                assign al_row[c*W +: W] = i_row[c*W +: W];
            end else begin : g_dly
                logic [W-1:0] dly [0:D-1];
                always_ff @(posedge i_clk) begin
                    if (i_rst) begin
                        for (int k = 0; k < D; k++) dly[k] <= '0;
                    end else begin
                        dly[0] <= i_row[c*W +: W];
                        for (int k = 1; k < D; k++) dly[k] <= dly[k-1];
                    end
                end
                assign al_row[c*W +: W] = dly[D-1];
            end
        end
    endgenerate

    generate
        if (N > 1) begin : g_vdly
            logic [N-2:0] vdl;
            always_ff @(posedge i_clk) begin
                if (i_rst || !i_en) begin
                    vdl <= '0;
                end else begin
                    vdl[0] <= i_valid;
                    for (int k = 1; k < N - 1; k++) vdl[k] <= vdl[k-1];
                end
            end
            assign v_raw = vdl[N-2];
        end else begin : g_vnodly
            assign v_raw = i_valid;
        end
    endgenerate

    assign v_al    = v_raw & i_en;
    assign v_in    = i_valid & i_en;
    assign last_in = v_in && (cnt == CW'(N - 1));
    assign done    = v_al && (row == CW'(N - 1));
    assign load    = done && (!o_valid || i_ready);

    // The final row bypasses the buffer so the matrix lands in o_C the same cycle.
    genvar r;
    generate
        for (r = 0; r < N - 1; r++) begin : g_asm
            assign next_C[r*W*N +: W*N] = asm_buf[r];
        end
    endgenerate
    assign next_C[(N-1)*W*N +: W*N] = al_row;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < N - 1; k++) asm_buf[k] <= '0;
            row <= '0;
        end else if (!i_en) begin
            row <= '0;
        end else if (v_al) begin
            for (int k = 0; k < N - 1; k++) begin
                if (row == CW'(k)) asm_buf[k] <= al_row;
            end
            row <= (row == CW'(N - 1)) ? '0 : row + 1'b1;
        end
    end

    // cnt counts lane-0 strobes of the matrix currently entering the skew.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            if (v_in) cnt <= (cnt == CW'(N - 1)) ? '0 : cnt + 1'b1;
            case (state)
                IDLE:  if (v_in) state <= last_in ? FLUSH : FILL;
                FILL:  if (last_in) state <= FLUSH;
                FLUSH: begin
                    if (done) begin
                        if (last_in)               state <= FLUSH;
                        else if (v_in || cnt != '0) state <= FILL;
                        else                       state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_C     <= '0;
            o_valid <= 1'b0;
        end else if (load) begin
            o_C     <= next_C;
            o_valid <= 1'b1;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

`ifdef RESULT_COLLECT_OVF_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_ovf <= 1'b0;
        end else if (done && o_valid && !i_ready) begin
            o_ovf <= 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_result_collect.sv
`default_nettype none
// tb_result_collect: table-driven vectors plus hand sequences, scoreboard on o_C handshakes.
module tb_result_collect;

    localparam int W     = 32;
    localparam int N     = 3;
    localparam int T_LEN = 48;

    typedef logic [W*N*N-1:0] mat_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           valid;
    logic           ready;
    logic [W*N-1:0] row;
    mat_t           C;
    logic           ovalid;
    logic           busy;
`ifdef RESULT_COLLECT_OVF_EN
    logic           ovf;
`endif

    always #5 clk = ~clk;

    result_collect #(.W(W), .N(N)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (en),
        .i_valid (valid),
        .i_row   (row),
        .i_ready (ready),
        .o_C     (C),
        .o_valid (ovalid),
        .o_busy  (busy)
`ifdef RESULT_COLLECT_OVF_EN
        ,
        .o_ovf   (ovf)
`endif
    );

    int   checks = 0;
    int   errors = 0;
    mat_t sb[$];

    logic           s_valid [T_LEN];
    logic           s_en    [T_LEN];
    logic           s_rdy   [T_LEN];
    logic           s_rst   [T_LEN];
    logic [W*N-1:0] s_row   [T_LEN];
    logic           m_valid [T_LEN];
    logic           m_busy  [T_LEN];
    logic           m_ovf   [T_LEN];
    mat_t           m_C     [T_LEN];

    typedef struct {
        int         t0, t1, t2;
        logic [W-1:0] base, mul;
        int         exp_lat;
    } vec_t;
    vec_t vt [4];

    task automatic chk(input string name, input mat_t act, input mat_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic mat_t mat_gen(input logic [W-1:0] base, input logic [W-1:0] mul);
        mat_t m;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                m[(i*N+j)*W +: W] = base + mul * W'(i) + W'(j);
        return m;
    endfunction

    task automatic clear_sched();
        for (int t = 0; t < T_LEN; t++) begin
            s_valid[t] = 1'b0; s_en[t] = 1'b1; s_rdy[t] = 1'b1; s_rst[t] = 1'b0;
            s_row[t] = '0; m_valid[t] = 1'b0; m_busy[t] = 1'b0; m_ovf[t] = 1'b0; m_C[t] = '0;
        end
    endtask

    // Rows issued at t0,t1,t2 (t2 < 0 leaves a partial matrix); lane c lags lane 0 by c cycles.
    task automatic sched_mat(input int t0, input int t1, input int t2,
                             input logic [W-1:0] base, input logic [W-1:0] mul, input bit push);
        int   ts [3];
        mat_t m;
        m  = mat_gen(base, mul);
        ts = '{t0, t1, t2};
        for (int k = 0; k < N; k++) begin
            if (ts[k] >= 0) begin
                s_valid[ts[k]] = 1'b1;
                for (int j = 0; j < N; j++) s_row[ts[k]+j][j*W +: W] = m[(k*N+j)*W +: W];
            end
        end
        if (push) sb.push_back(m);
    endtask

    task automatic run(input string name, input int len);
        rst = 1'b1; en = 1'b1; valid = 1'b0; ready = 1'b0; row = '0;
        @(posedge clk); @(posedge clk); #1;
        chk({name, "/rst_flags"}, {ovalid, busy}, '0);
        chk({name, "/rst_C"}, C, '0);
        rst = 1'b0;
        for (int t = 0; t < len; t++) begin
            rst = s_rst[t]; en = s_en[t]; valid = s_valid[t]; row = s_row[t]; ready = s_rdy[t];
            @(negedge clk);
            m_valid[t] = ovalid; m_busy[t] = busy; m_C[t] = C;
`ifdef RESULT_COLLECT_OVF_EN
            m_ovf[t] = ovf;
`endif
            if (ovalid && ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL %s/unexpected_out: got %0h at t=%0d expected no output", name, C, t);
                end else begin
                    chk({name, "/data"}, C, sb.pop_front());
                end
            end
            @(posedge clk); #1;
        end
        chk_i({name, "/missing_out"}, sb.size(), 0);
        sb.delete();
    endtask

    function automatic int first_valid();
        for (int t = 0; t < T_LEN; t++) if (m_valid[t]) return t;
        return -1;
    endfunction

    initial begin
        bit all_hi;
        vt[0] = '{0, 1, 2, 32'd0,          32'd10,         5};
        vt[1] = '{0, 3, 7, 32'd0,          32'd10,         10};
        vt[2] = '{2, 4, 5, 32'd7,          32'd100,        8};
        vt[3] = '{0, 1, 9, 32'hFFFF_FFF0,  32'h0100_0000,  12};

        for (int i = 0; i < 4; i++) begin
            clear_sched();
            sched_mat(vt[i].t0, vt[i].t1, vt[i].t2, vt[i].base, vt[i].mul, 1'b1);
            run($sformatf("vec%0d", i), 24);
            chk_i($sformatf("vec%0d/latency", i), first_valid(), vt[i].exp_lat);
            chk($sformatf("vec%0d/busy_fill", i), m_busy[vt[i].t0+1], 1);
            chk($sformatf("vec%0d/busy_done", i), m_busy[vt[i].exp_lat], 0);
            chk($sformatf("vec%0d/valid_pulse", i), m_valid[vt[i].exp_lat+1], 0);
        end

        // Back-to-back matrices with downstream stalled: second one is dropped.
        clear_sched();
        for (int t = 0; t < 20; t++) s_rdy[t] = 1'b0;
        sched_mat(0, 1, 2, 32'd0,   32'd10, 1'b1);
        sched_mat(3, 4, 5, 32'd500, 32'd10, 1'b0);
        run("hold", 26);
        chk_i("hold/latency", first_valid(), 5);
        all_hi = 1'b1;
        for (int t = 5; t <= 20; t++) all_hi &= m_valid[t];
        chk("hold/valid_held", all_hi, 1);
        chk("hold/C_held", m_C[19], mat_gen(32'd0, 32'd10));
        chk("hold/valid_fall", m_valid[21], 0);
`ifdef RESULT_COLLECT_OVF_EN
        chk("hold/ovf_pre", m_ovf[7], 0);
        chk("hold/ovf_set", m_ovf[8], 1);
        chk("hold/ovf_sticky", m_ovf[25], 1);
`endif

        // Second matrix completes on the acceptance cycle of the first.
        clear_sched();
        for (int t = 0; t < 7; t++) s_rdy[t] = 1'b0;
        sched_mat(0, 1, 2, 32'd0,   32'd10, 1'b1);
        sched_mat(3, 4, 5, 32'd700, 32'd10, 1'b1);
        run("b2b", 20);
        chk("b2b/valid_t7", m_valid[7], 1);
        chk("b2b/valid_t8", m_valid[8], 1);
        chk("b2b/C_t8", m_C[8], mat_gen(32'd700, 32'd10));
        chk("b2b/valid_t9", m_valid[9], 0);
`ifdef RESULT_COLLECT_OVF_EN
        chk("b2b/ovf", m_ovf[12], 0);
`endif

        // Enable dropped after two rows; partial matrix must be discarded.
        clear_sched();
        for (int t = 3; t <= 6; t++) s_en[t] = 1'b0;
        sched_mat(0, 1, -1, 32'd0,   32'd10, 1'b0);
        sched_mat(8, 9, 10, 32'd100, 32'd1,  1'b1);
        run("en", 24);
        chk("en/busy_fill", m_busy[2], 1);
        chk("en/busy_off5", m_busy[5], 0);
        chk("en/busy_off6", m_busy[6], 0);
        chk_i("en/latency", first_valid(), 13);

        // Reset in the middle of a fill while a held matrix and overflow are pending.
        clear_sched();
        for (int t = 0; t < 9; t++) s_rdy[t] = 1'b0;
        s_rst[8] = 1'b1;
        sched_mat(0, 1, 2, 32'd0,   32'd10, 1'b0);
        sched_mat(3, 4, 5, 32'd900, 32'd10, 1'b0);
        sched_mat(6, 7, -1, 32'd200, 32'd10, 1'b0);
        sched_mat(11, 12, 13, 32'd300, 32'd10, 1'b1);
        run("rst", 22);
        chk("rst/pre_valid_busy", {m_valid[8], m_busy[8]}, 2'b11);
        chk("rst/post_flags", {m_valid[9], m_busy[9]}, 0);
        chk("rst/post_C", m_C[9], '0);
        chk_i("rst/relatency", m_valid[16] && !m_valid[15] ? 16 : -1, 16);
`ifdef RESULT_COLLECT_OVF_EN
        chk("rst/ovf_pre", m_ovf[8], 1);
        chk("rst/ovf_post", m_ovf[9], 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
